// File: rtl/lsu_req_queue_if.sv
// lsu_req_queue_if: SRAM-like data bus (req/addr_ok/data_ok) between the LSU and memory.
interface lsu_req_queue_if #(parameter int ADDR_W = 32);
  logic              data_sram_req;
  logic              data_sram_wr;
  logic [1:0]        data_sram_size;
  logic [3:0]        data_sram_wstrb;
  logic [ADDR_W-1:0] data_sram_addr;
  logic [31:0]       data_sram_wdata;
  logic              data_sram_addr_ok;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/lsu_req_queue.sv
// lsu_req_queue: load/store request formatter with an in-order outstanding-request queue.
// Optional LSU_STAT_EN adds load/store/stall statistics counters.
module lsu_req_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [2:0]        in_op_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [31:0]       in_wdata_i,
  input  logic [TAG_W-1:0]  in_tag_i,
  output logic              in_ale_o,
  input  logic              flush_i,
  lsu_req_queue_if.master   bus,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_data_o,
  output logic [TAG_W-1:0]  resp_tag_o,
  output logic              resp_is_store_o,
  output logic              busy_o
`ifdef LSU_STAT_EN
  ,
  output logic [31:0]       stat_ld_cnt_o,
  output logic [31:0]       stat_st_cnt_o,
  output logic [31:0]       stat_stall_cnt_o
`endif
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [2:0]       op_q   [DEPTH];
  logic [1:0]       off_q  [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d, done_q, done_d, disc_q, disc_d;
  logic [PW-1:0]    wptr_q, wptr_d, fptr_q, fptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d, pend_q, pend_d;
  logic is_st, is_w, is_h, req, accept, fill, pop, h_vld, h_done, h_disc;
  logic [2:0]  f_op;
  logic [1:0]  f_off;
  logic [7:0]  f_b;
  logic [15:0] f_h;
  logic [31:0] fill_data;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    is_st    = in_op_i[2] & |in_op_i[1:0];
    is_w     = in_op_i == 3'd4 || in_op_i == 3'd7;
    is_h     = in_op_i == 3'd2 || in_op_i == 3'd3 || in_op_i == 3'd6;
    in_ale_o = in_valid_i & (is_w & |in_addr_i[1:0] | is_h & in_addr_i[0]);
    req      = in_valid_i & ~in_ale_o & ~flush_i & (count_q != CW'(DEPTH));
    accept   = req & bus.data_sram_addr_ok;
    in_ready_o = accept | in_ale_o;
    bus.data_sram_req   = req;
    bus.data_sram_wr    = is_st;
    bus.data_sram_size  = is_w ? 2'd2 : is_h ? 2'd1 : 2'd0;
    bus.data_sram_wstrb = ~is_st ? 4'b0000 : is_w ? 4'b1111 :
                          is_h ? (in_addr_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << in_addr_i[1:0];
    bus.data_sram_addr  = in_addr_i;
    bus.data_sram_wdata = is_w ? in_wdata_i : is_h ? {2{in_wdata_i[15:0]}} : {4{in_wdata_i[7:0]}};
  end
  // Load data is extracted from the lane selected by the entry's stored address offset.
  always_comb begin
    f_op  = op_q[fptr_q];
    f_off = off_q[fptr_q];
    f_b   = 8'(bus.data_sram_rdata >> {f_off, 3'b000});
    f_h   = f_off[1] ? bus.data_sram_rdata[31:16] : bus.data_sram_rdata[15:0];
    fill_data = f_op == 3'd0 ? {{24{f_b[7]}}, f_b} : f_op == 3'd1 ? {24'b0, f_b} :
                f_op == 3'd2 ? {{16{f_h[15]}}, f_h} : f_op == 3'd3 ? {16'b0, f_h} :
                f_op == 3'd4 ? bus.data_sram_rdata : 32'b0;
    fill   = bus.data_sram_data_ok & (pend_q != '0);
    h_vld  = vld_q[rptr_q];
    h_done = done_q[rptr_q];
    h_disc = disc_q[rptr_q];
    resp_valid_o    = h_vld & h_done & ~h_disc;
    pop             = h_vld & h_done & (h_disc | resp_ready_i);
    resp_data_o     = data_q[rptr_q];
    resp_tag_o      = tag_q[rptr_q];
    resp_is_store_o = op_q[rptr_q][2] & |op_q[rptr_q][1:0];
    busy_o          = count_q != '0;
  end
  always_comb begin
    wptr_d  = accept ? nxt(wptr_q) : wptr_q;
    fptr_d  = fill ? nxt(fptr_q) : fptr_q;
    rptr_d  = pop ? nxt(rptr_q) : rptr_q;
    count_d = count_q + CW'(accept) - CW'(pop);
    pend_d  = pend_q + CW'(accept) - CW'(fill);
    vld_d   = vld_q;
    done_d  = done_q;
    disc_d  = flush_i ? disc_q | vld_q : disc_q;
    if (fill) done_d[fptr_q] = 1'b1;
    if (accept) begin
      vld_d[wptr_q]  = 1'b1;
      done_d[wptr_q] = 1'b0;
      disc_d[wptr_q] = 1'b0;
    end
    if (pop) begin
      vld_d[rptr_q]  = 1'b0;
      done_d[rptr_q] = 1'b0;
      disc_d[rptr_q] = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      fptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
      vld_q   <= '0;
      done_q  <= '0;
      disc_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      fptr_q  <= fptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      disc_q  <= disc_d;
      if (accept) begin
        op_q[wptr_q]  <= in_op_i;
        off_q[wptr_q] <= in_addr_i[1:0];
        tag_q[wptr_q] <= in_tag_i;
      end
      if (fill) data_q[fptr_q] <= fill_data;
    end
  end
`ifdef LSU_STAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_ld_cnt_o    <= '0;
      stat_st_cnt_o    <= '0;
      stat_stall_cnt_o <= '0;
    end else begin
      stat_ld_cnt_o    <= stat_ld_cnt_o + 32'(accept & ~is_st);
      stat_st_cnt_o    <= stat_st_cnt_o + 32'(accept & is_st);
      stat_stall_cnt_o <= stat_stall_cnt_o + 32'(req & ~bus.data_sram_addr_ok);
    end
  end
`endif
endmodule

// File: tb/tb_lsu_req_queue.sv
// tb_lsu_req_queue: directed scenario tests for lsu_req_queue with DEPTH=2.
module tb_lsu_req_queue;
  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_ale, flush = 1'b0;
  logic [2:0]  in_op = '0;
  logic [31:0] in_addr = '0, in_wdata = '0;
  logic [4:0]  in_tag = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_is_store, busy;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  int vec = 0, err = 0;
  lsu_req_queue_if #(.ADDR_W(32)) bus ();
  lsu_req_queue #(.DEPTH(2), .ADDR_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op), .in_addr_i(in_addr),
    .in_wdata_i(in_wdata), .in_tag_i(in_tag), .in_ale_o(in_ale), .flush_i(flush),
    .bus(bus),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
    .resp_tag_o(resp_tag), .resp_is_store_o(resp_is_store), .busy_o(busy)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] tag);
    in_valid = 1'b1; in_op = op; in_addr = addr; in_wdata = wd; in_tag = tag;
  endtask
  task automatic test_reset;
    bus.data_sram_addr_ok = 1'b0; bus.data_sram_data_ok = 1'b0; bus.data_sram_rdata = '0;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; #1;
    vec++; if (bus.data_sram_req !== 1'b0) begin err++; $display("FAIL reset_req got %b want 0", bus.data_sram_req); end
    vec++; if (resp_valid !== 1'b0) begin err++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask
  task automatic test_load_ext;
    logic [31:0] exp [2];
    exp[0] = 32'hFFFFFF80; exp[1] = 32'h00000080;
    for (int i = 0; i < 2; i++) begin
      drive(3'(i), 32'h1003, 32'h0, 5'd3); bus.data_sram_addr_ok = 1'b1; #1;
      vec++; if (bus.data_sram_req !== 1'b1 || in_ready !== 1'b1) begin err++; $display("FAIL ldb_req got req=%b rdy=%b want 1/1", bus.data_sram_req, in_ready); end
      vec++; if (bus.data_sram_size !== 2'd0 || bus.data_sram_wr !== 1'b0 || bus.data_sram_wstrb !== 4'b0) begin err++; $display("FAIL ldb_fmt got size=%0d wr=%b wstrb=%b want 0/0/0000", bus.data_sram_size, bus.data_sram_wr, bus.data_sram_wstrb); end
      @(negedge clk);
      in_valid = 1'b0; bus.data_sram_addr_ok = 1'b0;
      bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h80112233; #1;
      vec++; if (resp_valid !== 1'b0) begin err++; $display("FAIL ldb_early_valid got %b want 0", resp_valid); end
      @(negedge clk);
      bus.data_sram_data_ok = 1'b0; #1;
      vec++; if (resp_valid !== 1'b1 || resp_data !== exp[i] || resp_tag !== 5'd3) begin err++; $display("FAIL ldb_resp op%0d got v=%b d=%h t=%0d want 1/%h/3", i, resp_valid, resp_data, resp_tag, exp[i]); end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0; #1;
      vec++; if (busy !== 1'b0) begin err++; $display("FAIL ldb_busy got %b want 0", busy); end
    end
  endtask
  task automatic test_store;
    logic [2:0]  op [2];
    logic [31:0] ad [2], wd [2], ew [2];
    logic [3:0]  es [2];
    op[0] = 3'd6; ad[0] = 32'h2002; wd[0] = 32'h0000BEEF; es[0] = 4'b1100; ew[0] = 32'hBEEFBEEF;
    op[1] = 3'd5; ad[1] = 32'h2001; wd[1] = 32'h0000005A; es[1] = 4'b0010; ew[1] = 32'h5A5A5A5A;
    for (int i = 0; i < 2; i++) begin
      drive(op[i], ad[i], wd[i], 5'd7); bus.data_sram_addr_ok = 1'b1; #1;
      vec++; if (bus.data_sram_req !== 1'b1 || bus.data_sram_wr !== 1'b1 || bus.data_sram_size !== 2'(1 - i)) begin err++; $display("FAIL st_req got req=%b wr=%b size=%0d want 1/1/%0d", bus.data_sram_req, bus.data_sram_wr, bus.data_sram_size, 1 - i); end
      vec++; if (bus.data_sram_wstrb !== es[i] || bus.data_sram_wdata !== ew[i]) begin err++; $display("FAIL st_fmt got wstrb=%b wdata=%h want %b/%h", bus.data_sram_wstrb, bus.data_sram_wdata, es[i], ew[i]); end
      @(negedge clk);
      in_valid = 1'b0; bus.data_sram_addr_ok = 1'b0;
      bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hDEADBEEF;
      @(negedge clk);
      bus.data_sram_data_ok = 1'b0; #1;
      vec++; if (resp_valid !== 1'b1 || resp_is_store !== 1'b1 || resp_data !== 32'h0) begin err++; $display("FAIL st_resp got v=%b st=%b d=%h want 1/1/0", resp_valid, resp_is_store, resp_data); end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask
  task automatic test_ale;
    drive(3'd4, 32'h3001, 32'h0, 5'd1); bus.data_sram_addr_ok = 1'b1; #1;
    vec++; if (in_ale !== 1'b1 || in_ready !== 1'b1 || bus.data_sram_req !== 1'b0) begin err++; $display("FAIL ale got ale=%b rdy=%b req=%b want 1/1/0", in_ale, in_ready, bus.data_sram_req); end
    @(negedge clk);
    in_valid = 1'b0; bus.data_sram_addr_ok = 1'b0; #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL ale_busy got %b want 0", busy); end
    drive(3'd2, 32'h3003, 32'h0, 5'd1); #1;
    vec++; if (in_ale !== 1'b1 || bus.data_sram_req !== 1'b0) begin err++; $display("FAIL ale_half got ale=%b req=%b want 1/0", in_ale, bus.data_sram_req); end
    in_valid = 1'b0;
  endtask
  task automatic test_back_to_back;
    bus.data_sram_addr_ok = 1'b1;
    drive(3'd4, 32'h100, 32'h0, 5'd1);
    @(negedge clk);
    drive(3'd4, 32'h104, 32'h0, 5'd2);
    @(negedge clk);
    drive(3'd4, 32'h108, 32'h0, 5'd3); #1;
    vec++; if (bus.data_sram_req !== 1'b0 || in_ready !== 1'b0) begin err++; $display("FAIL b2b_full got req=%b rdy=%b want 0/0", bus.data_sram_req, in_ready); end
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h11111111;
    @(negedge clk);
    bus.data_sram_data_ok = 1'b0; resp_ready = 1'b1; #1;
    vec++; if (resp_valid !== 1'b1 || resp_tag !== 5'd1 || resp_data !== 32'h11111111) begin err++; $display("FAIL b2b_first got v=%b t=%0d d=%h want 1/1/11111111", resp_valid, resp_tag, resp_data); end
    vec++; if (bus.data_sram_req !== 1'b0) begin err++; $display("FAIL b2b_still_full got req=%b want 0", bus.data_sram_req); end
    @(negedge clk);
    resp_ready = 1'b0; #1;
    vec++; if (bus.data_sram_req !== 1'b1 || in_ready !== 1'b1) begin err++; $display("FAIL b2b_third got req=%b rdy=%b want 1/1", bus.data_sram_req, in_ready); end
    @(negedge clk);
    in_valid = 1'b0; bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h22222222;
    @(negedge clk);
    bus.data_sram_rdata = 32'h33333333; resp_ready = 1'b1; #1;
    vec++; if (resp_valid !== 1'b1 || resp_tag !== 5'd2 || resp_data !== 32'h22222222) begin err++; $display("FAIL b2b_second got v=%b t=%0d d=%h want 1/2/22222222", resp_valid, resp_tag, resp_data); end
    @(negedge clk);
    bus.data_sram_data_ok = 1'b0; #1;
    vec++; if (resp_valid !== 1'b1 || resp_tag !== 5'd3 || resp_data !== 32'h33333333) begin err++; $display("FAIL b2b_third_resp got v=%b t=%0d d=%h want 1/3/33333333", resp_valid, resp_tag, resp_data); end
    @(negedge clk);
    resp_ready = 1'b0; #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL b2b_busy got %b want 0", busy); end
  endtask
  task automatic test_flush;
    bus.data_sram_addr_ok = 1'b1;
    drive(3'd4, 32'h200, 32'h0, 5'd4);
    @(negedge clk);
    drive(3'd4, 32'h204, 32'h0, 5'd5);
    @(negedge clk);
    in_valid = 1'b0; bus.data_sram_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'h44444444;
    @(negedge clk);
    bus.data_sram_rdata = 32'h55555555; #1;
    vec++; if (resp_valid !== 1'b0) begin err++; $display("FAIL flush_v0 got %b want 0", resp_valid); end
    @(negedge clk);
    bus.data_sram_data_ok = 1'b0; #1;
    vec++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin err++; $display("FAIL flush_v1 got v=%b busy=%b want 0/1", resp_valid, busy); end
    @(negedge clk); #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL flush_drain got busy=%b want 0", busy); end
    drive(3'd2, 32'h202, 32'h0, 5'd6); bus.data_sram_addr_ok = 1'b1; flush = 1'b1; #1;
    vec++; if (bus.data_sram_req !== 1'b0 || in_ready !== 1'b0) begin err++; $display("FAIL flush_gate got req=%b rdy=%b want 0/0", bus.data_sram_req, in_ready); end
    @(negedge clk);
    flush = 1'b0; #1;
    vec++; if (bus.data_sram_req !== 1'b1) begin err++; $display("FAIL flush_after_req got %b want 1", bus.data_sram_req); end
    @(negedge clk);
    in_valid = 1'b0; bus.data_sram_addr_ok = 1'b0;
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hABCD0000;
    @(negedge clk);
    bus.data_sram_data_ok = 1'b0; #1;
    vec++; if (resp_valid !== 1'b1 || resp_tag !== 5'd6 || resp_data !== 32'hFFFFABCD) begin err++; $display("FAIL flush_next got v=%b t=%0d d=%h want 1/6/ffffabcd", resp_valid, resp_tag, resp_data); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask
  task automatic test_backpressure;
    bus.data_sram_addr_ok = 1'b1;
    drive(3'd4, 32'h300, 32'h0, 5'd8);
    @(negedge clk);
    drive(3'd4, 32'h304, 32'h0, 5'd9);
    bus.data_sram_data_ok = 1'b1; bus.data_sram_rdata = 32'hAAAA0001;
    @(negedge clk);
    in_valid = 1'b0; bus.data_sram_addr_ok = 1'b0; bus.data_sram_rdata = 32'hBBBB0002;
    @(negedge clk);
    bus.data_sram_data_ok = 1'b0; #1;
    vec++; if (resp_valid !== 1'b1 || resp_tag !== 5'd8 || resp_data !== 32'hAAAA0001) begin err++; $display("FAIL bp_head got v=%b t=%0d d=%h want 1/8/aaaa0001", resp_valid, resp_tag, resp_data); end
    @(negedge clk);
    drive(3'd4, 32'h308, 32'h0, 5'd10); bus.data_sram_addr_ok = 1'b1; #1;
    vec++; if (resp_valid !== 1'b1 || resp_tag !== 5'd8 || bus.data_sram_req !== 1'b0) begin err++; $display("FAIL bp_hold got v=%b t=%0d req=%b want 1/8/0", resp_valid, resp_tag, bus.data_sram_req); end
    @(negedge clk);
    in_valid = 1'b0; bus.data_sram_addr_ok = 1'b0; resp_ready = 1'b1; #1;
    vec++; if (resp_tag !== 5'd8) begin err++; $display("FAIL bp_pop0 got t=%0d want 8", resp_tag); end
    @(negedge clk); #1;
    vec++; if (resp_valid !== 1'b1 || resp_tag !== 5'd9 || resp_data !== 32'hBBBB0002) begin err++; $display("FAIL bp_pop1 got v=%b t=%0d d=%h want 1/9/bbbb0002", resp_valid, resp_tag, resp_data); end
    @(negedge clk);
    resp_ready = 1'b0; #1;
    vec++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin err++; $display("FAIL bp_empty got busy=%b v=%b want 0/0", busy, resp_valid); end
  endtask
  initial begin
    test_reset;
    test_load_ext;
    test_store;
    test_ale;
    test_back_to_back;
    test_flush;
    test_backpressure;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
